// File: rtl/delay_measure.sv
// Per-channel stimulus/response delay measurement: steps through NUM_CH channels,
// counting clk cycles from stimulus rise to synchronised response, then flags done.
module delay_measure #(
    parameter int NUM_CH  = 20,
    parameter int TIMEOUT = 50000,
    parameter int RECOVER = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_sig,
    input  logic [NUM_CH-1:0]     resp_in,
    output logic [NUM_CH-1:0]     stim_out,
    output logic [NUM_CH*16-1:0]  data,
    output logic                  done_sig,
    output logic                  busy
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_RECOVER, S_DONE} state_t;

    state_t            r_state;
    logic              r_start_meta, r_start_s, r_start_d;
    logic [NUM_CH-1:0] r_resp_meta, r_resp_s;
    logic [CW-1:0]     r_ch;
    logic [15:0]       r_cnt;

    logic w_start_edge;
    logic w_resp_hit;

    assign w_start_edge = r_start_s & ~r_start_d;
    assign w_resp_hit   = r_resp_s[r_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_meta <= 1'b0;
            r_start_s    <= 1'b0;
            r_start_d    <= 1'b0;
            r_resp_meta  <= '0;
            r_resp_s     <= '0;
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_cnt        <= '0;
            stim_out     <= '0;
            data         <= '0;
            done_sig     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_start_meta <= start_sig;
            r_start_s    <= r_start_meta;
            r_start_d    <= r_start_s;
            r_resp_meta  <= resp_in;
            r_resp_s     <= r_resp_meta;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_edge) begin
                        r_state  <= S_MEASURE;
                        r_ch     <= '0;
                        r_cnt    <= '0;
                        stim_out <= NUM_CH'(1);
                        busy     <= 1'b1;
                        done_sig <= 1'b0;
                    end
                end
                S_MEASURE: begin
                    // response takes priority over timeout on the last counted cycle
                    if (w_resp_hit) begin
                        data[{r_ch, 4'b0000} +: 16] <= r_cnt;
                        stim_out <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RECOVER;
                    end else if (r_cnt == 16'(TIMEOUT - 1)) begin
                        data[{r_ch, 4'b0000} +: 16] <= 16'hFFFF;
                        stim_out <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == 16'(RECOVER - 1)) begin
                        r_cnt <= '0;
                        if (r_ch != CW'(NUM_CH - 1)) begin
                            r_ch     <= r_ch + CW'(1);
                            stim_out <= NUM_CH'(1) << (r_ch + CW'(1));
                            r_state  <= S_MEASURE;
                        end else begin
                            r_state  <= S_DONE;
                            done_sig <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
